// File: rtl/pmul_seq_if.sv
// Handshake bundle between the point-multiply sequencer, the key/base-point
// register block, the multiplier core and the result store.
interface pmul_seq_if;
    logic       start_i;
    logic       abort_i;
    logic       core_done_i;
    logic [7:0] k_addr_o;
    logic [2:0] gx_addr_o;
    logic [2:0] gy_addr_o;
    logic       core_ld_valid_o;
    logic [2:0] core_ld_idx_o;
    logic       core_go_o;
    logic [2:0] core_res_idx_o;
    logic [2:0] rx_addr_o;
    logic [2:0] ry_addr_o;
    logic       rx_wren_o;
    logic       ry_wren_o;
    logic       busy_o;
    logic       done_o;
    logic       err_timeout_o;

    modport slave (
        input  start_i, abort_i, core_done_i,
        output k_addr_o, gx_addr_o, gy_addr_o, core_ld_valid_o, core_ld_idx_o,
               core_go_o, core_res_idx_o, rx_addr_o, ry_addr_o, rx_wren_o,
               ry_wren_o, busy_o, done_o, err_timeout_o
    );

    modport master (
        output start_i, abort_i, core_done_i,
        input  k_addr_o, gx_addr_o, gy_addr_o, core_ld_valid_o, core_ld_idx_o,
               core_go_o, core_res_idx_o, rx_addr_o, ry_addr_o, rx_wren_o,
               ry_wren_o, busy_o, done_o, err_timeout_o
    );
endinterface

// File: rtl/pmul_seq.sv
// Point-multiply sequencer: loads operand words into the core, starts it, then
// drains result words. Optional RUN watchdog enabled by PMUL_SEQ_TIMEOUT_EN.
module pmul_seq #(
    parameter int pWORDS     = 8,
    parameter int pTIMEOUT_W = 20
) (
    input  logic       crypto_clk,
    input  logic       reset_n,
    pmul_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, LDRAIN, RUN, STORE, SDRAIN, DONE} state_t;

    localparam logic [2:0] LAST = 3'(pWORDS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ld_vld_q, ld_vld_d;
    logic [2:0] ld_idx_q, ld_idx_d;
    logic       wr_vld_q, wr_vld_d;
    logic [2:0] wr_idx_q, wr_idx_d;
    logic       go_q, go_d;
    logic       done_q, done_d;
    logic       cdone_q, cdone_d;
    logic       expire;

`ifdef PMUL_SEQ_TIMEOUT_EN
    // Expiry fires on the RUN cycle that brings the count to 2^W-1.
    localparam logic [pTIMEOUT_W-1:0] WDOG_LAST = {{(pTIMEOUT_W-1){1'b1}}, 1'b0};

    logic [pTIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                  err_q, err_d;

    always_comb begin
        wdog_d = '0;
        if (state_q == RUN) wdog_d = wdog_q + 1'b1;
        expire = (state_q == RUN) && (wdog_q == WDOG_LAST) && !bus.core_done_i && !cdone_q;
        err_d  = err_q;
        if (!bus.abort_i) begin
            if (state_q == IDLE && bus.start_i) err_d = 1'b0;
            else if (expire)                    err_d = 1'b1;
        end
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.err_timeout_o = err_q;
`else
    logic unused_tmo;
    assign unused_tmo        = ^pTIMEOUT_W;
    assign expire            = 1'b0;
    assign bus.err_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_vld_d = 1'b0;
        ld_idx_d = '0;
        wr_vld_d = 1'b0;
        wr_idx_d = '0;
        go_d     = 1'b0;
        done_d   = 1'b0;
        cdone_d  = 1'b0;
        if (bus.abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
                LOAD: begin
                    ld_vld_d = 1'b1;
                    ld_idx_d = cnt_q;
                    if (cnt_q == LAST) begin
                        state_d = LDRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                LDRAIN: begin
                    state_d = RUN;
                    go_d    = 1'b1;
                end
                // core_done_i is registered once before it moves the FSM.
                RUN: begin
                    cdone_d = bus.core_done_i;
                    if (cdone_q) begin
                        state_d = STORE;
                        cnt_d   = '0;
                    end else if (expire) begin
                        state_d = IDLE;
                    end
                end
                STORE: begin
                    wr_vld_d = 1'b1;
                    wr_idx_d = cnt_q;
                    if (cnt_q == LAST) begin
                        state_d = SDRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                SDRAIN: state_d = DONE;
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge crypto_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ld_vld_q <= 1'b0;
            ld_idx_q <= '0;
            wr_vld_q <= 1'b0;
            wr_idx_q <= '0;
            go_q     <= 1'b0;
            done_q   <= 1'b0;
            cdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_vld_q <= ld_vld_d;
            ld_idx_q <= ld_idx_d;
            wr_vld_q <= wr_vld_d;
            wr_idx_q <= wr_idx_d;
            go_q     <= go_d;
            done_q   <= done_d;
            cdone_q  <= cdone_d;
        end
    end

    assign bus.k_addr_o        = (state_q == LOAD)  ? {5'd0, cnt_q} : 8'd0;
    assign bus.gx_addr_o       = (state_q == LOAD)  ? cnt_q : 3'd0;
    assign bus.gy_addr_o       = (state_q == LOAD)  ? cnt_q : 3'd0;
    assign bus.core_res_idx_o  = (state_q == STORE) ? cnt_q : 3'd0;
    assign bus.core_ld_valid_o = ld_vld_q;
    assign bus.core_ld_idx_o   = ld_idx_q;
    assign bus.core_go_o       = go_q;
    assign bus.rx_wren_o       = wr_vld_q;
    assign bus.ry_wren_o       = wr_vld_q;
    assign bus.rx_addr_o       = wr_idx_q;
    assign bus.ry_addr_o       = wr_idx_q;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.done_o          = done_q;
endmodule

// File: tb/tb_pmul_seq.sv
// Self-checking bench for pmul_seq: a cycle-relative timing model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pmul_seq;
`ifdef PMUL_SEQ_TIMEOUT_EN
    localparam int TW     = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TW     = 20;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int NW      = 8;
    localparam int RUN_LEN = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    pmul_seq_if bus();

    pmul_seq #(.pWORDS(NW), .pTIMEOUT_W(TW)) dut (
        .crypto_clk (clk),
        .reset_n    (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a sequence accepted at cycle s, core_done accepted at cycle dacc;
    // all outputs follow as fixed offsets from those two events.
    bit act_m = 1'b0;
    int s_m = 0, dacc_m = -1, done_at = -1;
    bit err_m = 1'b0;

    always @(negedge clk) begin
        int r, q, ek, eldi, eres, ewa;
        bit eldv, ego, ewr;
        ek = 0; eldv = 0; eldi = 0; ego = 0; eres = 0; ewr = 0; ewa = 0;
        if (rst_n && act_m) begin
            r = cyc - s_m;
            if (r >= 1 && r <= NW) ek = r - 1;
            eldv = (r >= 2 && r <= NW + 1);
            if (eldv) eldi = r - 2;
            ego = (r == NW + 2);
            if (dacc_m >= 0) begin
                q = cyc - dacc_m;
                if (q >= 2 && q <= NW + 1) eres = q - 2;
                ewr = (q >= 3 && q <= NW + 2);
                if (ewr) ewa = q - 3;
            end
        end
        chk("k_addr",   int'(bus.k_addr_o),        ek);
        chk("gx_addr",  int'(bus.gx_addr_o),       ek);
        chk("gy_addr",  int'(bus.gy_addr_o),       ek);
        chk("ld_valid", int'(bus.core_ld_valid_o), int'(eldv));
        chk("ld_idx",   int'(bus.core_ld_idx_o),   eldi);
        chk("core_go",  int'(bus.core_go_o),       int'(ego));
        chk("res_idx",  int'(bus.core_res_idx_o),  eres);
        chk("rx_wren",  int'(bus.rx_wren_o),       int'(ewr));
        chk("ry_wren",  int'(bus.ry_wren_o),       int'(ewr));
        chk("rx_addr",  int'(bus.rx_addr_o),       ewa);
        chk("ry_addr",  int'(bus.ry_addr_o),       ewa);
        chk("busy",     int'(bus.busy_o),          int'(rst_n && act_m));
        chk("done",     int'(bus.done_o),          int'(rst_n && cyc == done_at));
        chk("err_tmo",  int'(bus.err_timeout_o),   int'(rst_n && err_m));
        // advance model with this cycle's inputs
        if (!rst_n) begin
            act_m = 0; dacc_m = -1; done_at = -1; err_m = 0;
        end else if (bus.abort_i) begin
            act_m = 0; dacc_m = -1; done_at = -1;
        end else if (act_m) begin
            r = cyc - s_m;
            if (dacc_m < 0 && bus.core_done_i && r >= NW + 2 && (!TMO_EN || r <= NW + 1 + RUN_LEN))
                dacc_m = cyc;
            if (dacc_m >= 0 && cyc - dacc_m == NW + 3) begin
                act_m = 0; done_at = cyc + 1;
            end else if (TMO_EN && dacc_m < 0 && r == NW + 1 + RUN_LEN) begin
                act_m = 0; err_m = 1;
            end
        end else if (bus.start_i) begin
            act_m = 1; s_m = cyc; dacc_m = -1; err_m = 0;
        end
    end

    int wr_cnt = 0, done_cnt = 0, first_wr = -1, done_cyc = -1, go_cyc = -1;
    always @(negedge clk) begin
        if (bus.rx_wren_o) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
        end
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.core_go_o) go_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_cnt = 0; done_cnt = 0; first_wr = -1; done_cyc = -1; go_cyc = -1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic start_seq(output int t0);
        bus.start_i = 1'b1;
        t0 = cyc;
        step();
        bus.start_i = 1'b0;
    endtask

    task automatic pulse_done(input int t);
        wait_to(t);
        bus.core_done_i = 1'b1;
        step();
        bus.core_done_i = 1'b0;
    endtask

    task automatic pulse_abort(input int t);
        wait_to(t);
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
    endtask

    initial begin
        int t0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.core_done_i = 1'b0;
        repeat (3) step();
        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_err",  int'(bus.err_timeout_o), 0);
        chk("reset_wren", int'(bus.rx_wren_o), 0);
        rst_n = 1'b1;
        step();

        // nominal sequence with the reference timing
        clr();
        start_seq(t0);
        pulse_done(t0 + 20);
        wait_to(t0 + 36);
        chk("t1_go_cyc",   go_cyc - t0,   10);
        chk("t1_first_wr", first_wr - t0, 23);
        chk("t1_done_cyc", done_cyc - t0, 32);
        chk("t1_wr_cnt",   wr_cnt,        8);
        chk("t1_done_cnt", done_cnt,      1);

        // early core_done and restart while busy are both ignored
        clr();
        start_seq(t0);
        pulse_done(t0 + 5);
        wait_to(t0 + 15);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        pulse_done(t0 + 17);
        wait_to(t0 + 34);
        chk("t2_first_wr", first_wr - t0, 20);
        chk("t2_wr_cnt",   wr_cnt,        8);
        chk("t2_done_cnt", done_cnt,      1);

        // abort after three result writes
        clr();
        start_seq(t0);
        pulse_done(t0 + 10);
        pulse_abort(t0 + 15);
        chk("t3_busy_after_abort", int'(bus.busy_o), 0);
        wait_to(t0 + 30);
        chk("t3_wr_cnt",   wr_cnt,   3);
        chk("t3_done_cnt", done_cnt, 0);

        // asynchronous reset during LOAD, then a clean sequence
        clr();
        start_seq(t0);
        wait_to(t0 + 4);
        rst_n = 1'b0;
        #1;
        chk("t4_async_busy", int'(bus.busy_o),   0);
        chk("t4_async_kadr", int'(bus.k_addr_o), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("t4_ld_seen", int'(bus.core_ld_valid_o), 0);
        clr();
        start_seq(t0);
        pulse_done(t0 + 12);
        wait_to(t0 + 28);
        chk("t4_wr_cnt",   wr_cnt,   8);
        chk("t4_done_cnt", done_cnt, 1);

        // abort in DONE suppresses done_o; abort beats start
        clr();
        start_seq(t0);
        pulse_done(t0 + 12);
        pulse_abort(t0 + 23);
        wait_to(t0 + 30);
        chk("t5_wr_cnt",   wr_cnt,   8);
        chk("t5_done_cnt", done_cnt, 0);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("t5_abort_wins", int'(bus.busy_o), 0);
        step();

        // watchdog behaviour
        clr();
        start_seq(t0);
        wait_to(t0 + 40);
`ifdef PMUL_SEQ_TIMEOUT_EN
        chk("t6_err",      int'(bus.err_timeout_o), 1);
        chk("t6_busy",     int'(bus.busy_o),        0);
        chk("t6_wr_cnt",   wr_cnt,   0);
        chk("t6_done_cnt", done_cnt, 0);
        clr();
        start_seq(t0);
        chk("t6_err_clr", int'(bus.err_timeout_o), 0);
        pulse_done(t0 + 24);
        wait_to(t0 + 42);
        chk("t7_err",      int'(bus.err_timeout_o), 0);
        chk("t7_first_wr", first_wr - t0, 27);
        chk("t7_wr_cnt",   wr_cnt,   8);
        chk("t7_done_cnt", done_cnt, 1);
`else
        chk("t6_still_busy", int'(bus.busy_o),        1);
        chk("t6_err",        int'(bus.err_timeout_o), 0);
        pulse_done(t0 + 41);
        wait_to(t0 + 58);
        chk("t6_wr_cnt",   wr_cnt,   8);
        chk("t6_done_cnt", done_cnt, 1);
`endif
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
